// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester access arbiter for the shared single-port data
// memory. The D (load/store) requester has fixed priority; the I (fetch)
// requester wins once it has been denied STARVE_LIMIT cycles in a row.
// Read data returns one cycle after the grant and is routed to its issuer.
module mem_arbiter #(
    parameter int LEN_REG      = 32,
    parameter int MEM_ADDR     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [MEM_ADDR-1:0] d_addr,
    input  logic [LEN_REG-1:0]  d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [LEN_REG-1:0]  d_rdata,
    input  logic                i_req,
    input  logic [MEM_ADDR-1:0] i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [LEN_REG-1:0]  i_rdata,
    output logic [MEM_ADDR-1:0] mem_a,
    output logic                mem_w,
    output logic [LEN_REG-1:0]  mem_d,
    input  logic [LEN_REG-1:0]  mem_q
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_D    = 2'd1,
        GNT_I    = 2'd2
    } gnt_sel_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    gnt_sel_t   sel;
    logic [3:0] starve_cnt;
    logic       starving;
    logic       rd_pend;
    logic       rd_own;

    assign starving = (starve_cnt >= LIMIT);

    // Grant selection: starvation override first, then D priority, then I.
    always_comb begin
        sel = GNT_NONE;
        if (!rst) begin
            if (i_req && starving)
                sel = GNT_I;
            else if (d_req)
                sel = GNT_D;
            else if (i_req)
                sel = GNT_I;
        end
    end

    assign d_gnt = (sel == GNT_D);
    assign i_gnt = (sel == GNT_I);

    // Memory pin drive follows the winner; idle pins are held at zero.
    always_comb begin
        mem_a = '0;
        mem_w = 1'b0;
        mem_d = '0;
        case (sel)
            GNT_D: begin
                mem_a = d_addr;
                mem_w = d_we;
                mem_d = d_wdata;
            end
            GNT_I: begin
                mem_a = i_addr;
            end
            default: begin
                mem_a = '0;
            end
        endcase
    end

    // Read-return tracking: remember whether last cycle issued a read and for whom.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_own  <= 1'b0;
        end else begin
            rd_pend <= (d_gnt & ~d_we) | i_gnt;
            rd_own  <= i_gnt;
        end
    end

    // Count consecutive cycles in which I is requesting but denied, saturating.
    always_ff @(posedge clk) begin
        if (rst || !i_req || i_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != 4'hF)
            starve_cnt <= starve_cnt + 4'd1;
    end

    // Route returning read data; rst also masks a read issued just before reset.
    always_comb begin
        d_rvalid = rd_pend & ~rd_own & ~rst;
        i_rvalid = rd_pend &  rd_own & ~rst;
        d_rdata  = d_rvalid ? mem_q : '0;
        i_rdata  = i_rvalid ? mem_q : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed request sequence, a behavioural SRAM
// connected to the memory pins, and a reference model of arbitration and
// read return checked every cycle, plus literal spot checks.
module tb_mem_arbiter;

    localparam int LEN_REG  = 32;
    localparam int MEM_ADDR = 16;
    localparam int LIMIT    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                d_req = 1'b0;
    logic                d_we = 1'b0;
    logic [MEM_ADDR-1:0] d_addr = '0;
    logic [LEN_REG-1:0]  d_wdata = '0;
    logic                d_gnt;
    logic                d_rvalid;
    logic [LEN_REG-1:0]  d_rdata;
    logic                i_req = 1'b0;
    logic [MEM_ADDR-1:0] i_addr = '0;
    logic                i_gnt;
    logic                i_rvalid;
    logic [LEN_REG-1:0]  i_rdata;
    logic [MEM_ADDR-1:0] mem_a;
    logic                mem_w;
    logic [LEN_REG-1:0]  mem_d;
    logic [LEN_REG-1:0]  mem_q = '0;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .LEN_REG      (LEN_REG),
        .MEM_ADDR     (MEM_ADDR),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .mem_a    (mem_a),
        .mem_w    (mem_w),
        .mem_d    (mem_d),
        .mem_q    (mem_q)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous SRAM: one-cycle read, read-before-write.
    logic [LEN_REG-1:0] sram [0:65535];
    initial begin
        for (int unsigned k = 0; k < 65536; k++) sram[k] = '0;
        sram[16'h0004] = 32'h12345678;
    end
    always @(posedge clk) begin
        if (mem_w) sram[mem_a] <= mem_d;
        mem_q <= sram[mem_a];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents as a sparse map, I wait count, and
    // the one read that may be in flight.
    logic [31:0] model_mem [int unsigned];
    int          wait_cnt = 0;
    bit          m_pend   = 0;
    bit          m_own_i  = 0;
    logic [31:0] m_data   = '0;

    initial model_mem[32'h4] = 32'h12345678;

    function automatic logic [31:0] model_rd(input logic [15:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        bit          eg_d, eg_i;
        logic [15:0] ea;
        logic        ew;
        logic [31:0] ed;
        eg_d = 0;
        eg_i = 0;
        if (!rst) begin
            if (i_req && wait_cnt >= LIMIT) eg_i = 1;
            else if (d_req)                 eg_d = 1;
            else if (i_req)                 eg_i = 1;
        end
        ea = eg_d ? d_addr : (eg_i ? i_addr : 16'h0);
        ew = eg_d ? d_we : 1'b0;
        ed = (eg_d && d_we) ? d_wdata : 32'h0;
        chk("d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
        chk("i_gnt", {31'b0, i_gnt}, {31'b0, eg_i});
        chk("mem_a", {16'b0, mem_a}, {16'b0, ea});
        chk("mem_w", {31'b0, mem_w}, {31'b0, ew});
        chk("mem_d", mem_d, ed);
        chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, m_pend && !m_own_i && !rst});
        chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, m_pend && m_own_i && !rst});
        chk("d_rdata", d_rdata, (m_pend && !m_own_i && !rst) ? m_data : 32'h0);
        chk("i_rdata", i_rdata, (m_pend && m_own_i && !rst) ? m_data : 32'h0);
        if (rst) begin
            wait_cnt = 0;
            m_pend   = 0;
            m_own_i  = 0;
        end else begin
            m_pend  = eg_i || (eg_d && !d_we);
            m_own_i = eg_i;
            m_data  = eg_i ? model_rd(i_addr) : model_rd(d_addr);
            if (eg_d && d_we) model_mem[int'(d_addr)] = d_wdata;
            if (i_req && !eg_i) wait_cnt = (wait_cnt < 15) ? wait_cnt + 1 : 15;
            else                wait_cnt = 0;
        end
    end

    // Apply one cycle of inputs, return just after the following negedge.
    task automatic cyc(input logic r, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [31:0] dd,
                       input logic ir, input logic [15:0] ia);
        @(posedge clk);
        #1;
        rst = r; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        i_req = ir; i_addr = ia;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // reset held two cycles with both requesting
        cyc(1, 1, 0, 16'h0010, 0, 1, 16'h0004);
        chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
        cyc(1, 1, 0, 16'h0010, 0, 1, 16'h0004);
        chk("rst_i_gnt", {31'b0, i_gnt}, 32'h0);
        chk("rst_mem_w", {31'b0, mem_w}, 32'h0);
        // D store wins first cycle after reset
        cyc(0, 1, 1, 16'h0010, 32'hDEADBEEF, 1, 16'h0004);
        chk("st_d_gnt", {31'b0, d_gnt}, 32'h1);
        chk("st_mem_w", {31'b0, mem_w}, 32'h1);
        cyc(0, 1, 0, 16'h0010, 0, 1, 16'h0004);
        chk("ld_mem_w", {31'b0, mem_w}, 32'h0);
        cyc(0, 0, 0, 16'h0000, 0, 1, 16'h0004);
        chk("ld_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("i_alone_gnt", {31'b0, i_gnt}, 32'h1);
        cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        chk("i_rdata", i_rdata, 32'h12345678);
        chk("i_ret_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        // starvation: continuous D loads with I requesting
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 16'h0020 + 16'(k), 0, 1, 16'h0004);
            chk("starve_d_wins", {31'b0, d_gnt}, 32'h1);
        end
        cyc(0, 1, 0, 16'h0024, 0, 1, 16'h0004);
        chk("starve_i_gnt", {31'b0, i_gnt}, 32'h1);
        chk("starve_d_gnt", {31'b0, d_gnt}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 16'h0024 + 16'(k), 0, 1, 16'h0008);
            chk("restart_i_gnt", {31'b0, i_gnt}, 32'h0);
        end
        cyc(0, 1, 0, 16'h0028, 0, 1, 16'h0008);
        chk("restart_i_gnt2", {31'b0, i_gnt}, 32'h1);
        // interleaved returns
        cyc(0, 1, 0, 16'h0010, 0, 0, 16'h0000);
        cyc(0, 0, 0, 16'h0000, 0, 1, 16'h0004);
        chk("il_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("il_i_rvalid0", {31'b0, i_rvalid}, 32'h0);
        cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        chk("il_i_rdata", i_rdata, 32'h12345678);
        chk("il_d_rvalid0", {31'b0, d_rvalid}, 32'h0);
        // load then store to same address: load sees old data
        cyc(0, 1, 0, 16'h0010, 0, 0, 16'h0000);
        cyc(0, 1, 1, 16'h0010, 32'hCAFEF00D, 0, 16'h0000);
        chk("sal_old", d_rdata, 32'hDEADBEEF);
        cyc(0, 1, 0, 16'h0010, 0, 0, 16'h0000);
        cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        chk("sal_new", d_rdata, 32'hCAFEF00D);
        // reset mid-read, then counter must start from zero
        cyc(0, 1, 0, 16'h0030, 0, 1, 16'h0004);
        cyc(0, 0, 0, 16'h0000, 0, 1, 16'h0004);
        chk("rm_i_gnt", {31'b0, i_gnt}, 32'h1);
        cyc(1, 1, 0, 16'h0030, 0, 1, 16'h0008);
        chk("rm_no_i_rvalid", {31'b0, i_rvalid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 16'h0030 + 16'(k), 0, 1, 16'h0008);
            chk("rm_d_wins", {31'b0, d_gnt}, 32'h1);
        end
        cyc(0, 1, 0, 16'h0034, 0, 1, 16'h0008);
        chk("rm_i_gnt5", {31'b0, i_gnt}, 32'h1);
        cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
